// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter shared by the program loader, video scanout and a 6502 CPU.
// Also sequences the CPU reset pulse after power-up and after every program download.
module ram_arbiter #(
  parameter int RESET_CYCLES  = 8,
  parameter int VID_MAX_BURST = 16
) (
  input  logic        clk_ram,
  input  logic        reset,
  input  logic        ld_req,
  input  logic        ld_done,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_wdata,
  input  logic        ld_we,
  input  logic        vid_req,
  input  logic [15:0] vid_addr,
  output logic        vid_rvalid,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic        cpu_reset,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic [1:0]  owner
);

  localparam int RST_W = $clog2(RESET_CYCLES + 1);
  localparam int VID_W = $clog2(VID_MAX_BURST + 1);

  typedef enum logic [1:0] {
    OWN_CPU  = 2'd0,
    OWN_VID  = 2'd1,
    OWN_LOAD = 2'd2,
    OWN_CRST = 2'd3
  } owner_t;

  owner_t           owner_q, owner_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [VID_W-1:0] vid_cnt_q, vid_cnt_d;
  logic             pend_q, pend_d;
  logic             vid_rvalid_q;
  logic             crst_active;

  assign crst_active = (owner_q == OWN_CRST) && (rst_cnt_q != '0);

  always_ff @(posedge clk_ram) begin
    if (reset) begin
      owner_q      <= OWN_CRST;
      rst_cnt_q    <= RST_W'(RESET_CYCLES);
      vid_cnt_q    <= '0;
      pend_q       <= 1'b0;
      vid_rvalid_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      rst_cnt_q    <= rst_cnt_d;
      vid_cnt_q    <= vid_cnt_d;
      pend_q       <= pend_d;
      vid_rvalid_q <= (owner_q == OWN_VID);
    end
  end

  // A reboot request is honoured in the same cycle ld_done arrives, so the CPU
  // never gets a cycle against a freshly downloaded but not yet rebooted image.
  always_comb begin
    owner_d   = OWN_CPU;
    rst_cnt_d = rst_cnt_q;
    vid_cnt_d = '0;
    pend_d    = pend_q | ld_done;
    if (ld_req) begin
      owner_d   = OWN_LOAD;
      rst_cnt_d = '0;
      if (crst_active) pend_d = 1'b1;
    end else if (crst_active) begin
      rst_cnt_d = rst_cnt_q - RST_W'(1);
      owner_d   = (rst_cnt_q == RST_W'(1)) ? OWN_CPU : OWN_CRST;
    end else if (pend_q || ld_done) begin
      owner_d   = OWN_CRST;
      rst_cnt_d = RST_W'(RESET_CYCLES);
      pend_d    = 1'b0;
    end else if (vid_req && (vid_cnt_q != VID_W'(VID_MAX_BURST))) begin
      owner_d   = OWN_VID;
      vid_cnt_d = vid_cnt_q + VID_W'(1);
    end
  end

  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = 1'b0;
    cpu_rdy   = 1'b0;
    cpu_reset = 1'b0;
    case (owner_q)
      OWN_CPU: begin
        ram_we  = cpu_we;
        cpu_rdy = 1'b1;
      end
      OWN_VID: begin
        ram_addr = vid_addr;
      end
      OWN_LOAD: begin
        ram_addr  = ld_addr;
        ram_wdata = ld_wdata;
        ram_we    = ld_we;
      end
      default: begin
        cpu_rdy   = 1'b1;
        cpu_reset = 1'b1;
      end
    endcase
    if (reset) begin
      ram_we    = 1'b0;
      cpu_reset = 1'b1;
    end
  end

  assign vid_rvalid = vid_rvalid_q & ~reset;
  assign owner      = owner_q;

endmodule
